// File: rtl/fib_seq_ctrl_if.sv
// Handshake bundle between the Fibonacci sequencer and its start/tick source and RAM.
// master is the sequencer side; slave drives start/tick and observes the RAM port.
interface fib_seq_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 11
);
  logic          start;
  logic          tick;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (
    input  start, tick,
    output ram_we, ram_addr, ram_din, busy, done, ovf
  );

  modport slave (
    output start, tick,
    input  ram_we, ram_addr, ram_din, busy, done, ovf
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Writes F(0)..F(2^AW-1) into RAM one per clock on a start edge, then steps the address on tick.
// Start-to-done latency 2^AW+1 cycles; no backpressure, start edges during generation are dropped.
module fib_seq_ctrl #(
  parameter int AW = 4,
  parameter int DW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  fib_seq_ctrl_if.master    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_DISP = 2'd2;

  logic [1:0]    r_state;
  logic          r_start_q;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_a_sat;
  logic          r_b_sat;
  logic [DW-1:0] r_din;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic          r_done;
  logic          r_ovf;

  logic          w_edge;
  logic          w_last;
  logic [DW:0]   w_sum;
  logic          w_next_sat;
  logic [DW-1:0] w_next_b;

  assign w_edge     = bus.start & ~r_start_q;
  assign w_last     = (r_addr == {AW{1'b1}});
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  // Saturation is tracked as a flag so a genuine all-ones term does not read as overflow.
  assign w_next_sat = w_sum[DW] | r_a_sat | r_b_sat;
  assign w_next_b   = w_next_sat ? {DW{1'b1}} : w_sum[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_a       <= '0;
      r_b       <= {{(DW-1){1'b0}}, 1'b1};
      r_a_sat   <= 1'b0;
      r_b_sat   <= 1'b0;
      r_din     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      r_done    <= 1'b0;
      if ((r_state == S_IDLE || r_state == S_DISP) && w_edge) begin
        // F(0) is presented in the first GEN cycle, so the write port is loaded here.
        r_state <= S_GEN;
        r_a     <= '0;
        r_b     <= {{(DW-1){1'b0}}, 1'b1};
        r_a_sat <= 1'b0;
        r_b_sat <= 1'b0;
        r_din   <= '0;
        r_addr  <= '0;
        r_we    <= 1'b1;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          S_GEN: begin
            if (w_last) begin
              r_state <= S_DISP;
              r_we    <= 1'b0;
              r_addr  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_din   <= r_b;
              r_ovf   <= r_ovf | r_b_sat;
              r_a     <= r_b;
              r_a_sat <= r_b_sat;
              r_b     <= w_next_b;
              r_b_sat <= w_next_sat;
            end
          end
          S_DISP: begin
            r_we <= 1'b0;
            if (bus.tick) begin
              r_addr <= r_addr + AW'(1);
            end
          end
          S_IDLE: begin
            r_we <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ram_we   = r_we;
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_din;
  assign bus.busy     = (r_state == S_GEN);
  assign bus.done     = r_done;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Drives two sequencers (DW=11 and DW=8) in lockstep and checks them against saturated Fibonacci tables.
module tb_fib_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_v;
  logic tick_v;

  always #5 clk = ~clk;

  fib_seq_ctrl_if #(.AW(4), .DW(11)) bus11 ();
  fib_seq_ctrl_if #(.AW(4), .DW(8))  bus8 ();

  assign bus11.start = start_v;
  assign bus11.tick  = tick_v;
  assign bus8.start  = start_v;
  assign bus8.tick   = tick_v;

  fib_seq_ctrl #(.AW(4), .DW(11)) dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11.master));
  fib_seq_ctrl #(.AW(4), .DW(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.master));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_t[2][16];
  int sat_idx[2];
  int dw_of[2] = '{11, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected term k is the true Fibonacci number clamped to the all-ones value.
  task automatic build_model();
    for (int d = 0; d < 2; d++) begin
      longint f0 = 0;
      longint f1 = 1;
      longint t;
      longint mx = (longint'(1) << dw_of[d]) - 1;
      sat_idx[d] = 16;
      for (int k = 0; k < 16; k++) begin
        exp_t[d][k] = int'((f0 > mx) ? mx : f0);
        if (f0 > mx && sat_idx[d] == 16) sat_idx[d] = k;
        t  = f0 + f1;
        f0 = f1;
        f1 = t;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dut(input string tag, input int d, input logic [31:0] we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [31:0] busy, input logic [31:0] done,
                           input logic [31:0] ovf);
    logic [31:0] g_we, g_addr, g_din, g_busy, g_done, g_ovf;
    if (d == 0) begin
      g_we = bus11.ram_we; g_addr = bus11.ram_addr; g_din = bus11.ram_din;
      g_busy = bus11.busy; g_done = bus11.done;    g_ovf = bus11.ovf;
    end else begin
      g_we = bus8.ram_we;  g_addr = bus8.ram_addr;  g_din = bus8.ram_din;
      g_busy = bus8.busy;  g_done = bus8.done;      g_ovf = bus8.ovf;
    end
    chk($sformatf("%s/dw%0d.we",   tag, dw_of[d]), g_we,   we);
    chk($sformatf("%s/dw%0d.addr", tag, dw_of[d]), g_addr, addr);
    chk($sformatf("%s/dw%0d.din",  tag, dw_of[d]), g_din,  din);
    chk($sformatf("%s/dw%0d.busy", tag, dw_of[d]), g_busy, busy);
    chk($sformatf("%s/dw%0d.done", tag, dw_of[d]), g_done, done);
    chk($sformatf("%s/dw%0d.ovf",  tag, dw_of[d]), g_ovf,  ovf);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) check_dut(tag, d, 0, 0, 0, 0, 0, 0);
  endtask

  // Caller sets up the start edge; abort_at >= 0 pulls reset in the middle of that write cycle.
  task automatic run_gen(input bit noise, input int abort_at);
    step();
    for (int k = 0; k < 16; k++) begin
      for (int d = 0; d < 2; d++)
        check_dut($sformatf("gen%0d", k), d, 1, k, exp_t[d][k], 1, 0, (k >= sat_idx[d]) ? 1 : 0);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        return;
      end
      if (noise) begin
        tick_v  = 1'($urandom_range(0, 1));
        start_v = 1'($urandom_range(0, 1));
      end
      step();
    end
    for (int d = 0; d < 2; d++)
      check_dut("done", d, 0, 0, exp_t[d][15], 0, 1, (sat_idx[d] <= 15) ? 1 : 0);
    start_v = 1'b0;
    tick_v  = 1'b0;
    step();
    for (int d = 0; d < 2; d++)
      check_dut("disp0", d, 0, 0, exp_t[d][15], 0, 0, (sat_idx[d] <= 15) ? 1 : 0);
  endtask

  // Starts from address 0 in DISP; random idle gaps between ticks.
  task automatic disp_ticks(input int n);
    int ea = 0;
    for (int i = 0; i < n; i++) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        step();
        chk("disp_hold/dw11.addr", bus11.ram_addr, ea);
        chk("disp_hold/dw8.addr",  bus8.ram_addr,  ea);
      end
      tick_v = 1'b1;
      step();
      tick_v = 1'b0;
      ea = (ea + 1) % 16;
      chk("disp_tick/dw11.addr", bus11.ram_addr, ea);
      chk("disp_tick/dw8.addr",  bus8.ram_addr,  ea);
      chk("disp_tick/dw11.we",   bus11.ram_we,   0);
      chk("disp_tick/dw8.busy",  bus8.busy,      0);
    end
  endtask

  initial begin
    build_model();
    start_v = 1'b1;
    tick_v  = 1'b0;
    rst_n   = 1'b0;
    repeat (3) step();
    check_reset_vals("in_rst");
    rst_n = 1'b1;
    repeat (50) begin
      step();
      check_reset_vals("idle_start_held");
    end

    start_v = 1'b0;
    step();
    start_v = 1'b1;
    run_gen(1'b0, -1);

    disp_ticks(17);

    start_v = 1'b1;
    run_gen(1'b1, -1);

    disp_ticks(3);
    tick_v  = 1'b1;
    start_v = 1'b1;
    run_gen(1'b1, -1);

    step();
    start_v = 1'b1;
    run_gen(1'b0, 7);
    repeat (2) step();
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    repeat (10) begin
      step();
      check_reset_vals("post_rst_idle");
    end
    start_v = 1'b0;
    step();
    check_reset_vals("post_rst_low");
    start_v = 1'b1;
    run_gen(1'b0, -1);

    repeat (3) begin
      disp_ticks($urandom_range(1, 20));
      start_v = 1'b1;
      run_gen(1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencer for the Fibonacci display datapath. It owns a single-port RAM's write port and address: on a start request it writes the first 2^AW Fibonacci terms (F(0) at address 0 upward), one per clock. It then hands the address over to display mode, where a slow tick steps through the stored terms for the seven-segment driver. It replaces the loose counter/FSM/generator combination at the top level with one controller that has a defined handshake.

## Interface

- AW, 4, RAM address width; sequence length 2^AW terms
- DW, 11, RAM data width; term width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request, already synchronous to clk (debounced externally); rising edge triggers generation
- tick  in  1  one-cycle strobe that advances the display address
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  AW  RAM address, registered
- ram_din  out  DW  RAM write data, registered
- busy  out  1  high while in GEN
- done  out  1  one-cycle pulse on GEN→DISP
- ovf  out  1  sticky; a term exceeded DW bits during the last generation

## Operation

- States:
  - IDLE: reset state.
  - GEN: writes terms.
  - DISP: read/display.
- Start edge: start_q register holds last start; edge = start & ~start_q. start_q resets to 1, so a start held high through reset does not trigger.
- IDLE → GEN on edge. DISP → GEN on edge (regenerate from address 0). Edges during GEN are ignored.
- GEN entry:
  - a=0, b=1, ram_addr=0, ovf=0.
- Each GEN cycle:
  - ram_we=1, ram_din=a, at ram_addr.
  - Then a←b, b←sat(a+b), ram_addr←ram_addr+1.
- Arithmetic: the sum is computed DW+1 bits wide. If the carry-out is set, the result is {DW{1}} and ovf is set. Once a or b is saturated, every later term is {DW{1}}.
- GEN → DISP after the write at address 2^AW−1:
  - ram_we=0, ram_addr=0, done pulses.
- DISP:
  - ram_we=0.
  - tick increments ram_addr, wrapping 2^AW−1 → 0.
  - ram_din holds its last value.
- tick is ignored in IDLE and GEN. If tick and a start edge occur in the same cycle in DISP, start wins: state GEN, ram_addr=0.
- Reset mid-GEN aborts immediately. RAM contents are undefined/partial; the controller returns to IDLE and does not resume.

## Timing

- Reset values:
  - state=IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, ovf=0, a=0, b=1, start_q=1.
- Start edge sampled at edge N. From cycle N+1 for 2^AW cycles:
  - busy=1, ram_we=1.
  - Address k is written in cycle N+1+k with F(k) (saturated).
- Cycle N+1+2^AW: state DISP, busy=0, ram_we=0, ram_addr=0, done=1 for exactly this cycle.
- Total start-to-done latency: 2^AW+1 cycles.
- DISP: ram_addr changes the cycle after the clock edge on which tick=1. Read latency belongs to the RAM, not this block.
- ovf is set in the cycle the first saturated term is presented on ram_din. It holds until the next GEN entry.

## Test plan

1. Reset with start=1 held, then release rst_n → stays IDLE. Outputs are all reset values, no ram_we for 50 cycles.
2. AW=4, DW=11, start 0→1 → 16 consecutive writes:
   - addr 0..15 = 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610.
   - done one cycle later with ram_addr=0; ovf=0.
3. AW=4, DW=8 → addrs 0..13 = 0..233; addrs 14 and 15 = 255; ovf=1 from the addr-14 write onward. A following regeneration with DW=8 re-clears ovf on GEN entry.
4. In DISP, issue 17 ticks → ram_addr goes 1,2,…,15,0,1. Ticks injected during GEN leave the write sequence unchanged.
5. In DISP, assert tick and a start edge in the same cycle → GEN with a write to addr 0 next cycle. A start edge mid-GEN is ignored: exactly 16 writes, one done.
6. Assert rst_n low at write addr 7 → outputs go to reset values asynchronously. After release the block sits in IDLE until a new start edge, then performs a full 16-write sequence.
